// File: rtl/ddr_wr_arb_4ch.sv
// Purpose : round-robin arbiter that lets one of four write channels own the DDR
//           controller's write port for a whole burst, with a watchdog that
//           forcibly releases a channel that never completes.
// Latency : winner registered one cycle after its request is seen in IDLE;
//           address/length/data and handshakes are routed combinationally.
// Backpr. : the controller's ddr_wrdy/ddr_wdata_req/ddr_wdone go only to the
//           granted channel; other channels wait with their requests held.
// Ports   : ddr_clk, ddr_rst (sync, active high); ch_wreq/ch_waddr/ch_wr_len/
//           ch_wdata per-channel request slices; ch_wrdy/ch_wdone/ch_wdata_req
//           per-channel handshakes; ddr_* controller-side request and handshakes;
//           grant (one-hot), busy, err_timeout (sticky), err_ch (timed-out channel).
module ddr_wr_arb_4ch #(
  parameter int ADDR_WIDTH  = 27,
  parameter int LEN_WIDTH   = 16,
  parameter int DQ_WIDTH    = 16,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                      ddr_clk,
  input  logic                      ddr_rst,
  input  logic [3:0]                ch_wreq,
  input  logic [4*ADDR_WIDTH-1:0]   ch_waddr,
  input  logic [4*LEN_WIDTH-1:0]    ch_wr_len,
  input  logic [4*8*DQ_WIDTH-1:0]   ch_wdata,
  output logic [3:0]                ch_wrdy,
  output logic [3:0]                ch_wdone,
  output logic [3:0]                ch_wdata_req,
  output logic                      ddr_wreq,
  output logic [ADDR_WIDTH-1:0]     ddr_waddr,
  output logic [LEN_WIDTH-1:0]      ddr_wr_len,
  output logic [8*DQ_WIDTH-1:0]     ddr_wdata,
  input  logic                      ddr_wrdy,
  input  logic                      ddr_wdone,
  input  logic                      ddr_wdata_req,
  output logic [3:0]                grant,
  output logic                      busy,
  output logic                      err_timeout,
  output logic [1:0]                err_ch
);

  localparam int DW = 8 * DQ_WIDTH;
  // The watchdog trips on the cycle it holds TIMEOUT_CYC-1, so the block is
  // back in IDLE exactly TIMEOUT_CYC edges after entering REQ.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rr_ptr;
  logic [1:0]  gnt_idx;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_vld;
  logic [15:0] wdog;
  logic        wdog_exp;
  logic        finish_ev;
  logic        timeout_ev;
  logic        active;

  // Round-robin search: walk offsets high to low so the nearest requester
  // to rr_ptr is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    cand    = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (ch_wreq[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // State register
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. In REQ a data request beats a dropped channel request;
  // in BURST a genuine completion beats the watchdog.
  always_comb begin
    state_nxt  = state;
    wdog_exp   = (wdog == WDOG_LAST);
    finish_ev  = 1'b0;
    timeout_ev = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (wdog_exp) begin
          state_nxt  = S_IDLE;
          timeout_ev = 1'b1;
        end else if (ddr_wdata_req) begin
          state_nxt = S_BURST;
        end else if (!ch_wreq[gnt_idx]) begin
          state_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        if (ddr_wdone) begin
          state_nxt = S_IDLE;
          finish_ev = 1'b1;
        end else if (wdog_exp) begin
          state_nxt  = S_IDLE;
          timeout_ev = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant index, round-robin pointer, watchdog and error capture
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      rr_ptr      <= 2'd0;
      gnt_idx     <= 2'd0;
      wdog        <= 16'd0;
      err_timeout <= 1'b0;
      err_ch      <= 2'd0;
    end else begin
      if (state == S_IDLE) begin
        if (win_vld) begin
          gnt_idx <= win_idx;
          wdog    <= 16'd0;
        end
      end else begin
        wdog <= wdog + 16'd1;
      end
      // A dropped request in REQ deliberately leaves rr_ptr alone so the
      // same channel keeps its turn.
      if (finish_ev || timeout_ev) rr_ptr <= gnt_idx + 2'd1;
      if (timeout_ev) begin
        err_timeout <= 1'b1;
        err_ch      <= gnt_idx;
      end
    end
  end

  // Outputs. Gated by reset as well so an aborted burst never shows a
  // completion pulse during the reset cycle.
  always_comb begin
    active       = (state != S_IDLE) && !ddr_rst;
    grant        = 4'b0000;
    busy         = 1'b0;
    ddr_wreq     = 1'b0;
    ddr_waddr    = '0;
    ddr_wr_len   = '0;
    ddr_wdata    = '0;
    ch_wrdy      = 4'b0000;
    ch_wdone     = 4'b0000;
    ch_wdata_req = 4'b0000;
    if (active) begin
      grant[gnt_idx]        = 1'b1;
      busy                  = 1'b1;
      ddr_wreq              = (state == S_REQ) && ch_wreq[gnt_idx];
      ddr_waddr             = ch_waddr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ddr_wr_len            = ch_wr_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
      ddr_wdata             = ch_wdata[int'(gnt_idx)*DW +: DW];
      ch_wrdy[gnt_idx]      = ddr_wrdy;
      ch_wdata_req[gnt_idx] = ddr_wdata_req;
      ch_wdone[gnt_idx]     = (state == S_BURST) && ddr_wdone;
    end
  end

endmodule

// File: tb/tb_ddr_wr_arb_4ch.sv
module tb_ddr_wr_arb_4ch;

  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DQ = 16;
  localparam int DW = 8 * DQ;

  logic            ddr_clk = 1'b0;
  logic            ddr_rst;
  logic [3:0]      ch_wreq;
  logic [4*AW-1:0] ch_waddr;
  logic [4*LW-1:0] ch_wr_len;
  logic [4*DW-1:0] ch_wdata;
  logic            ddr_wrdy, ddr_wdone, ddr_wdata_req;

  logic [3:0]    ch_wrdy, ch_wdone, ch_wdata_req, grant;
  logic          ddr_wreq, busy, err_timeout;
  logic [AW-1:0] ddr_waddr;
  logic [LW-1:0] ddr_wr_len;
  logic [DW-1:0] ddr_wdata;
  logic [1:0]    err_ch;

  logic [3:0]    t_ch_wrdy, t_ch_wdone, t_ch_wdata_req, t_grant;
  logic          t_ddr_wreq, t_busy, t_err_timeout;
  logic [AW-1:0] t_ddr_waddr;
  logic [LW-1:0] t_ddr_wr_len;
  logic [DW-1:0] t_ddr_wdata;
  logic [1:0]    t_err_ch;

  int nvec = 0;
  int nerr = 0;
  int pulses;
  logic [DW-1:0] pat;

  always #5 ddr_clk = ~ddr_clk;

  ddr_wr_arb_4ch #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ)) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
    .ch_wreq(ch_wreq), .ch_waddr(ch_waddr), .ch_wr_len(ch_wr_len), .ch_wdata(ch_wdata),
    .ch_wrdy(ch_wrdy), .ch_wdone(ch_wdone), .ch_wdata_req(ch_wdata_req),
    .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len), .ddr_wdata(ddr_wdata),
    .ddr_wrdy(ddr_wrdy), .ddr_wdone(ddr_wdone), .ddr_wdata_req(ddr_wdata_req),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_ch(err_ch)
  );

  ddr_wr_arb_4ch #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ), .TIMEOUT_CYC(8)) dut_to (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
    .ch_wreq(ch_wreq), .ch_waddr(ch_waddr), .ch_wr_len(ch_wr_len), .ch_wdata(ch_wdata),
    .ch_wrdy(t_ch_wrdy), .ch_wdone(t_ch_wdone), .ch_wdata_req(t_ch_wdata_req),
    .ddr_wreq(t_ddr_wreq), .ddr_waddr(t_ddr_waddr), .ddr_wr_len(t_ddr_wr_len), .ddr_wdata(t_ddr_wdata),
    .ddr_wrdy(ddr_wrdy), .ddr_wdone(ddr_wdone), .ddr_wdata_req(ddr_wdata_req),
    .grant(t_grant), .busy(t_busy), .err_timeout(t_err_timeout), .err_ch(t_err_ch)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  // Entered just after the edge that put the arbiter in REQ for exp_g.
  // Runs a one-beat burst, the single IDLE cycle, and returns after the
  // next arbitration edge.
  task automatic burst(input logic [3:0] exp_g, input string tag);
    chk({tag, "_grant"}, grant, exp_g);
    chk({tag, "_wreq"}, ddr_wreq, 1'b1);
    ddr_wdata_req = 1'b1;
    #1;
    chk({tag, "_wdreq"}, ch_wdata_req, exp_g);
    tick();
    ddr_wdata_req = 1'b0;
    ddr_wdone     = 1'b1;
    #1;
    chk({tag, "_wdone"}, ch_wdone, exp_g);
    tick();
    ddr_wdone = 1'b0;
    #1;
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_idle_gnt"}, grant, 4'b0000);
    tick();
  endtask

  initial begin
    ddr_rst       = 1'b1;
    ch_wreq       = 4'b0000;
    ch_waddr      = '0;
    ch_wr_len     = '0;
    ch_wdata      = '0;
    ddr_wrdy      = 1'b0;
    ddr_wdone     = 1'b0;
    ddr_wdata_req = 1'b0;
    tick();
    tick();

    // Reset state, and outputs held off while reset is high
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_errch", err_ch, 2'd0);
    ch_wreq = 4'b1111; ddr_wrdy = 1'b1; ddr_wdone = 1'b1; ddr_wdata_req = 1'b1;
    #1;
    chk("rst_wreq", ddr_wreq, 1'b0);
    chk("rst_chout", {ch_wrdy, ch_wdone, ch_wdata_req}, 12'h000);
    tick();
    chk("rst_hold_busy", busy, 1'b0);

    // All four requesting: 0,1,2,3,0 with an IDLE cycle between bursts
    ddr_rst = 1'b0; ddr_wrdy = 1'b0; ddr_wdone = 1'b0; ddr_wdata_req = 1'b0;
    #1;
    chk("rr_first_idle", busy, 1'b0);
    chk("idle_addr_zero", ddr_waddr, 27'h0);
    tick();
    burst(4'b0001, "rr0");
    burst(4'b0010, "rr1");
    burst(4'b0100, "rr2");
    burst(4'b1000, "rr3");
    burst(4'b0001, "rr0b");

    // Now in REQ for ch1; ch1 drops before any data request
    chk("drop_gnt", grant, 4'b0010);
    ch_wreq = 4'b0000;
    #1;
    chk("drop_wreq", ddr_wreq, 1'b0);
    tick();
    chk("drop_idle", busy, 1'b0);
    chk("drop_nodone", ch_wdone, 4'b0000);
    ch_wreq = 4'b1010;
    tick();
    chk("drop_rewin", grant, 4'b0010);

    // Data request wins over a simultaneous request drop
    ch_wreq = 4'b1000; ddr_wdata_req = 1'b1;
    #1;
    chk("prio_wdreq", ch_wdata_req, 4'b0010);
    chk("prio_wreq", ddr_wreq, 1'b0);
    tick();
    ddr_wdata_req = 1'b0; ddr_wrdy = 1'b1;
    #1;
    chk("prio_burst", grant, 4'b0010);
    chk("wrdy_route", ch_wrdy, 4'b0010);
    ddr_wdone = 1'b1;
    #1;
    chk("prio_wdone", ch_wdone, 4'b0010);
    tick();

    // Controller handshakes in IDLE are not routed
    ddr_wrdy = 1'b0; ddr_wdata_req = 1'b1;
    #1;
    chk("idle_ign", {ch_wdone, ch_wdata_req, grant}, 12'h000);
    ddr_wdone = 1'b0; ddr_wdata_req = 1'b0;
    tick();
    chk("rr_ch3", grant, 4'b1000);

    // Reset in the middle of a burst
    ddr_wdata_req = 1'b1;
    tick();
    ddr_wdata_req = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    ch_wreq = 4'b1001; ddr_rst = 1'b1; ddr_wdone = 1'b1;
    #1;
    chk("rst_nodone", ch_wdone, 4'b0000);
    tick();
    ddr_rst = 1'b0; ddr_wdone = 1'b0;
    #1;
    chk("rst_abort", {busy, grant}, 5'b0);
    tick();
    chk("rst_rr0", grant, 4'b0001);

    // Single channel with a long burst and distinct per-channel slices
    ch_wreq = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      ch_waddr[i*AW +: AW]  = 27'h7000000 + 27'(i);
      ch_wr_len[i*LW +: LW] = 16'hF000 + 16'(i);
      pat = {4{32'hA5000000 + 32'(i)}};
      ch_wdata[i*DW +: DW]  = pat;
    end
    ch_waddr[2*AW +: AW]  = 27'h0000500;
    ch_wr_len[2*LW +: LW] = 16'd160;
    ch_wreq = 4'b0100;
    #1;
    chk("c2_idle_len", ddr_wr_len, 16'd0);
    tick();
    chk("c2_addr", ddr_waddr, 27'h0000500);
    chk("c2_len", ddr_wr_len, 16'd160);
    pat = {4{32'hA5000002}};
    chk("c2_data", ddr_wdata, pat);
    pulses = 0;
    for (int b = 0; b < 160; b++) begin
      ddr_wdata_req = 1'b1;
      #1;
      if (ch_wdata_req === 4'b0100) pulses++;
      tick();
    end
    ddr_wdata_req = 1'b0;
    chk("c2_pulses", pulses, 160);
    ddr_wdone = 1'b1;
    #1;
    chk("c2_wdone", ch_wdone, 4'b0100);
    tick();
    ddr_wdone = 1'b0;
    ch_wreq = 4'b0000;
    #1;
    chk("c2_end", busy, 1'b0);

    // Watchdog on the TIMEOUT_CYC=8 instance: ch3 never completes
    ddr_rst = 1'b1;
    tick();
    tick();
    ddr_rst = 1'b0;
    ch_wreq = 4'b1000;
    #1;
    chk("to_rst_err", t_err_timeout, 1'b0);
    tick();
    chk("to_gnt", t_grant, 4'b1000);
    for (int c = 1; c < 8; c++) tick();
    chk("to_still_busy", t_busy, 1'b1);
    tick();
    chk("to_idle", t_busy, 1'b0);
    chk("to_err", t_err_timeout, 1'b1);
    chk("to_errch", t_err_ch, 2'd3);
    chk("long_wd_noerr", err_timeout, 1'b0);
    ch_wreq = 4'b1001;
    tick();
    chk("to_next_ch0", t_grant, 4'b0001);
    chk("to_sticky", t_err_timeout, 1'b1);
    chk("long_wd_gnt", grant, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
